// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - ID-side and EX-side signal bundle of the ID/EX pipeline stage
interface id_ex_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_RegWrite, id_alusrc, id_branch, id_branchnot, id_jump, id_MemRead, id_MemWrite;
    logic [1:0]    id_aluop, id_MemtoReg, id_RegDst;
    logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;

    logic          ex_RegWrite, ex_alusrc, ex_branch, ex_branchnot, ex_jump, ex_MemRead, ex_MemWrite;
    logic [1:0]    ex_aluop, ex_MemtoReg, ex_RegDst;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;

    modport master (
        output id_RegWrite, id_alusrc, id_branch, id_branchnot, id_jump, id_MemRead, id_MemWrite,
        output id_aluop, id_MemtoReg, id_RegDst,
        output id_pc4, id_rd1, id_rd2, id_imm,
        output id_rs, id_rt, id_rd,
        input  ex_RegWrite, ex_alusrc, ex_branch, ex_branchnot, ex_jump, ex_MemRead, ex_MemWrite,
        input  ex_aluop, ex_MemtoReg, ex_RegDst,
        input  ex_pc4, ex_rd1, ex_rd2, ex_imm,
        input  ex_rs, ex_rt, ex_rd
    );

    modport slave (
        input  id_RegWrite, id_alusrc, id_branch, id_branchnot, id_jump, id_MemRead, id_MemWrite,
        input  id_aluop, id_MemtoReg, id_RegDst,
        input  id_pc4, id_rd1, id_rd2, id_imm,
        input  id_rs, id_rt, id_rd,
        output ex_RegWrite, ex_alusrc, ex_branch, ex_branchnot, ex_jump, ex_MemRead, ex_MemWrite,
        output ex_aluop, ex_MemtoReg, ex_RegDst,
        output ex_pc4, ex_rd1, ex_rd2, ex_imm,
        output ex_rs, ex_rt, ex_rd
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall detection and bubble counter
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    id_ex_if.slave        bus,
    output logic          stall,
    output logic [CW-1:0] bubble_cnt
);
    typedef struct packed {
        logic          reg_write;
        logic          alusrc;
        logic          branch;
        logic          branchnot;
        logic          jump;
        logic          mem_read;
        logic          mem_write;
        logic [1:0]    aluop;
        logic [1:0]    memto_reg;
        logic [1:0]    reg_dst;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } stage_t;

    stage_t        id_s;
    stage_t        ex_d, ex_q;
    logic [CW-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        id_s.reg_write = bus.id_RegWrite;
        id_s.alusrc    = bus.id_alusrc;
        id_s.branch    = bus.id_branch;
        id_s.branchnot = bus.id_branchnot;
        id_s.jump      = bus.id_jump;
        id_s.mem_read  = bus.id_MemRead;
        id_s.mem_write = bus.id_MemWrite;
        id_s.aluop     = bus.id_aluop;
        id_s.memto_reg = bus.id_MemtoReg;
        id_s.reg_dst   = bus.id_RegDst;
        id_s.pc4       = bus.id_pc4;
        id_s.rd1       = bus.id_rd1;
        id_s.rd2       = bus.id_rd2;
        id_s.imm       = bus.id_imm;
        id_s.rs        = bus.id_rs;
        id_s.rt        = bus.id_rt;
        id_s.rd        = bus.id_rd;
    end

    // rt is compared even for instructions that do not read it; a spurious stall only costs a cycle
    assign stall = ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == bus.id_rs) || (ex_q.rt == bus.id_rt));

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!hold) begin
            if (flush || stall) begin
                ex_d = '0;
                if (bubble_cnt_q != {CW{1'b1}}) begin
                    bubble_cnt_d = bubble_cnt_q + CW'(1);
                end
            end else begin
                ex_d = id_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt       = bubble_cnt_q;
    assign bus.ex_RegWrite  = ex_q.reg_write;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_branchnot = ex_q.branchnot;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_MemRead   = ex_q.mem_read;
    assign bus.ex_MemWrite  = ex_q.mem_write;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_MemtoReg  = ex_q.memto_reg;
    assign bus.ex_RegDst    = ex_q.reg_dst;
    assign bus.ex_pc4       = ex_q.pc4;
    assign bus.ex_rd1       = ex_q.rd1;
    assign bus.ex_rd2       = ex_q.rd2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven bench for id_ex_stage with a 4-bit bubble counter
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    // control packing: {RegWrite, alusrc, branch, branchnot, jump, MemRead, MemWrite, aluop, MemtoReg, RegDst}
    localparam logic [12:0] C_NOP = 13'b0000000_00_00_00;
    localparam logic [12:0] C_LW  = 13'b1100010_00_01_00;
    localparam logic [12:0] C_R   = 13'b1000000_10_00_01;
    localparam logic [12:0] C_SW  = 13'b0100001_00_00_00;
    localparam logic [12:0] C_BEQ = 13'b0010000_01_00_00;

    typedef struct {
        logic          hold;
        logic          flush;
        logic [12:0]   ctrl;
        logic [RW-1:0] rs, rt, rd;
        logic [DW-1:0] base;
        logic          exp_stall;
        logic [12:0]   exp_ctrl;
        logic [RW-1:0] exp_rs, exp_rt, exp_rd;
        logic [DW-1:0] exp_base;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          flush;
    logic          stall;
    logic [CW-1:0] bubble_cnt;
    int            total = 0;
    int            bad = 0;
    vec_t          vecs[$];

    id_ex_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .flush      (flush),
        .bus        (bus),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ex_ctrl();
        return {bus.ex_RegWrite, bus.ex_alusrc, bus.ex_branch, bus.ex_branchnot, bus.ex_jump,
                bus.ex_MemRead, bus.ex_MemWrite, bus.ex_aluop, bus.ex_MemtoReg, bus.ex_RegDst};
    endfunction

    function automatic logic [DW-1:0] dat(input logic [DW-1:0] base, input int k);
        return (base == '0) ? '0 : base + DW'(k);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [12:0] c, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [DW-1:0] base);
        {bus.id_RegWrite, bus.id_alusrc, bus.id_branch, bus.id_branchnot, bus.id_jump,
         bus.id_MemRead, bus.id_MemWrite, bus.id_aluop, bus.id_MemtoReg, bus.id_RegDst} = c;
        bus.id_rs  = rs;
        bus.id_rt  = rt;
        bus.id_rd  = rd;
        bus.id_pc4 = base;
        bus.id_rd1 = base + 1;
        bus.id_rd2 = base + 2;
        bus.id_imm = base + 3;
    endtask

    task automatic check_ex(input string tag, input logic [12:0] c, input logic [RW-1:0] rs,
                            input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                            input logic [DW-1:0] base, input logic [CW-1:0] cnt);
        check({tag, ".ctrl"}, DW'(ex_ctrl()), DW'(c));
        check({tag, ".rs"},   DW'(bus.ex_rs), DW'(rs));
        check({tag, ".rt"},   DW'(bus.ex_rt), DW'(rt));
        check({tag, ".rd"},   DW'(bus.ex_rd), DW'(rd));
        check({tag, ".pc4"},  bus.ex_pc4, dat(base, 0));
        check({tag, ".rd1"},  bus.ex_rd1, dat(base, 1));
        check({tag, ".rd2"},  bus.ex_rd2, dat(base, 2));
        check({tag, ".imm"},  bus.ex_imm, dat(base, 3));
        check({tag, ".cnt"},  DW'(bubble_cnt), DW'(cnt));
    endtask

    task automatic add(input logic h, input logic f, input logic [12:0] c, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic [RW-1:0] rd, input logic [DW-1:0] b,
                       input logic es, input logic [12:0] ec, input logic [RW-1:0] ers,
                       input logic [RW-1:0] ert, input logic [RW-1:0] erd, input logic [DW-1:0] eb,
                       input logic [CW-1:0] ecnt);
        vec_t v;
        v.hold = h; v.flush = f; v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.base = b;
        v.exp_stall = es; v.exp_ctrl = ec; v.exp_rs = ers; v.exp_rt = ert; v.exp_rd = erd;
        v.exp_base = eb; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        drive(C_LW, 5'd3, 5'd8, 5'd0, 32'd100);
        @(posedge clk); #1;
        check("reset.stall", DW'(stall), 0);
        check_ex("reset", C_NOP, 0, 0, 0, 0, 0);

        //  hold flush ctrl   rs  rt  rd  base   stall exp_ctrl rs rt rd base  cnt
        add(0, 0, C_LW,  3, 8, 0, 100,  0, C_LW,  3, 8, 0, 100, 0);  // lw loads
        add(0, 0, C_R,   8, 9, 10, 200, 1, C_NOP, 0, 0, 0, 0,   1);  // load-use on rs
        add(0, 0, C_R,   8, 9, 10, 200, 0, C_R,   8, 9, 10, 200, 1); // re-presented R-type
        add(0, 0, C_LW,  2, 0, 0, 300,  0, C_LW,  2, 0, 0, 300, 1);  // lw rt=0
        add(0, 0, C_R,   0, 5, 6, 400,  0, C_R,   0, 5, 6, 400, 1);  // r0 guard
        add(0, 0, C_LW,  1, 8, 0, 500,  0, C_LW,  1, 8, 0, 500, 1);
        add(0, 0, C_R,   4, 8, 7, 600,  1, C_NOP, 0, 0, 0, 0,   2);  // load-use on rt
        add(0, 1, C_SW,  1, 2, 0, 700,  0, C_NOP, 0, 0, 0, 0,   3);  // flush squashes sw
        add(0, 0, C_LW,  1, 8, 0, 800,  0, C_LW,  1, 8, 0, 800, 3);
        add(0, 1, C_R,   8, 3, 4, 850,  1, C_NOP, 0, 0, 0, 0,   4);  // flush+stall: one bump
        add(0, 0, C_LW,  1, 8, 0, 900,  0, C_LW,  1, 8, 0, 900, 4);
        add(1, 0, C_R,   8, 3, 4, 950,  1, C_LW,  1, 8, 0, 900, 4);  // hold during stall
        add(1, 0, C_R,   8, 3, 4, 950,  1, C_LW,  1, 8, 0, 900, 4);
        add(1, 0, C_R,   8, 3, 4, 950,  1, C_LW,  1, 8, 0, 900, 4);
        add(0, 0, C_R,   8, 3, 4, 950,  1, C_NOP, 0, 0, 0, 0,   5);  // hold released
        add(1, 1, C_BEQ, 1, 2, 0, 990,  0, C_NOP, 0, 0, 0, 0,   5);  // hold beats flush
        add(0, 0, C_BEQ, 1, 2, 0, 1000, 0, C_BEQ, 1, 2, 0, 1000, 5);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            hold  = vecs[i].hold;
            flush = vecs[i].flush;
            drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].base);
            #1;
            check($sformatf("v%0d.stall", i), DW'(stall), DW'(vecs[i].exp_stall));
            @(posedge clk); #1;
            check_ex($sformatf("v%0d", i), vecs[i].exp_ctrl, vecs[i].exp_rs, vecs[i].exp_rt,
                     vecs[i].exp_rd, vecs[i].exp_base, vecs[i].exp_cnt);
            @(negedge clk);
        end

        // saturation: counter is at 5, 20 flushes must pin it at 15
        hold = 1'b0; flush = 1'b1;
        drive(C_SW, 1, 2, 0, 32'd1100);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (n == 9) check("sat.reach", DW'(bubble_cnt), 15);
        end
        check_ex("sat", C_NOP, 0, 0, 0, 0, 15);

        // reset in the middle of a held stall
        @(negedge clk);
        flush = 1'b0;
        drive(C_LW, 1, 8, 0, 32'd1200);
        @(posedge clk); #1;
        check_ex("pre_rst", C_LW, 1, 8, 0, 1200, 15);
        @(negedge clk);
        hold = 1'b1; rst = 1'b1;
        drive(C_R, 8, 3, 4, 32'd1300);
        #1;
        check("pre_rst.stall", DW'(stall), 1);
        @(posedge clk); #1;
        check("rst.stall", DW'(stall), 0);
        check_ex("rst", C_NOP, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        check_ex("post_rst", C_R, 8, 3, 4, 1300, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
